// File: rtl/latch_wr_sequencer.sv
// Purpose : write-side sequencer for an always_latch storage array; runs SETUP/OPEN/HOLD per write.
// Latency : accept edge -> lat_en high 1 cycle later, wr_done 2 cycles later; one write per 3 cycles.
// Backpressure: req_ready low in SETUP/OPEN; request must hold addr/data stable until accepted.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            write request handshake (req_ready decoded from state only)
//   req_addr [AW], req_data [WIDTH] request payload, sampled on accept
//   lat_en [DEPTH]                 registered one-hot latch enable, high only in OPEN
//   lat_d [WIDTH]                  registered latch data, changes only on accept
//   wr_done, wr_err                one-cycle pulses during HOLD (wr_err: address was out of range)
module latch_wr_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_data,
    output logic [DEPTH-1:0] lat_en,
    output logic [WIDTH-1:0] lat_d,
    output logic             wr_done,
    output logic             wr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    addr_q;
    logic             err_q;
    logic             accept;
    logic [DEPTH-1:0] lat_en_d;
    logic             wr_done_d;
    logic             wr_err_d;

    // Ready depends on state only so the requester never sees a comb path
    // from its own valid back to ready.
    assign req_ready = (state_q == IDLE) || (state_q == HOLD);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the registered-output precursors. Outputs are decoded
    // from the *next* state so that lat_en/wr_done are flops that line up
    // exactly with the state they belong to.
    always_comb begin
        state_d   = state_q;
        lat_en_d  = '0;
        wr_done_d = 1'b0;
        wr_err_d  = 1'b0;

        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = OPEN;
            OPEN:    state_d = HOLD;
            HOLD:    state_d = accept ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase

        // addr_q/err_q were captured on the edge into SETUP, so they are
        // already valid when deciding the enable for OPEN.
        if (state_d == OPEN && !err_q) begin
            for (int i = 0; i < DEPTH; i++) begin
                lat_en_d[i] = (32'(addr_q) == i);
            end
        end

        // err_q is only overwritten on the HOLD->SETUP edge, where
        // wr_done_d is already low, so it is safe to use here.
        wr_done_d = (state_d == HOLD);
        wr_err_d  = wr_done_d && err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_en  <= '0;
            lat_d   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            lat_en  <= lat_en_d;
            wr_done <= wr_done_d;
            wr_err  <= wr_err_d;
            // Data only moves on accept (entering SETUP); lat_en is low on
            // that edge, so data and enable never change together.
            if (accept) begin
                lat_d  <= req_data;
                addr_q <= req_addr;
                err_q  <= (32'(req_addr) >= DEPTH);
            end
        end
    end

endmodule

// File: doc/latch_wr_sequencer.md
# latch_wr_sequencer

Write-side controller that sits directly upstream of a latch-based storage array built from `always_latch` cells. It accepts write requests over a valid/ready handshake and registers the address and data. It then drives a three-phase SETUP/OPEN/HOLD sequence, so the one-hot latch enable is only ever open while the latch data input is stable, and closes a full cycle before that data may change. It contains no storage itself; the downstream array consumes `lat_en` and `lat_d` directly.

## Interface
- `WIDTH`, 8, data width of each latch word
- `DEPTH`, 4, number of latch words (2..256, need not be a power of two)
- `AW`, `$clog2(DEPTH)`, address width (derived, not overridden)
- `clk`  input  1  clock; all state updates on rising edge
- `rst_n`  input  1  reset, asynchronous and active-low
- `req_valid`  input  1  write request present
- `req_ready`  output  1  block can accept a request this cycle
- `req_addr`  input  AW  target word index
- `req_data`  input  WIDTH  word to write
- `lat_en`  output  DEPTH  one-hot latch enable, registered
- `lat_d`  output  WIDTH  latch data input, registered
- `wr_done`  output  1  one-cycle pulse, write sequence completed
- `wr_err`  output  1  one-cycle pulse, completed sequence had `req_addr >= DEPTH`

## Operation
- Clock/reset decision: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- State machine has four states: IDLE, SETUP, OPEN, HOLD. It enters IDLE on reset.
- `req_ready` is combinational from state: 1 in IDLE and HOLD, 0 in SETUP and OPEN. It does not depend on `req_valid`.
- Accept occurs when `req_valid && req_ready`. On accept, the block registers:
  - `lat_d <= req_data`
  - internal `addr_q <= req_addr`
  - internal `err_q <= (req_addr >= DEPTH)`
- Transitions:
  - IDLE → SETUP on accept, otherwise stays in IDLE.
  - SETUP → OPEN unconditionally.
  - OPEN → HOLD unconditionally.
  - HOLD → SETUP on accept, otherwise HOLD → IDLE.
- `lat_en` behaviour:
  - Registered. It is 1 in bit `addr_q` during OPEN only, and all zeros in every other state.
  - If `err_q` is set, `lat_en` stays all zeros through OPEN.
- `lat_d` changes only on an accept edge. It holds its value in all other cycles, including IDLE.
- `wr_done` is 1 exactly while in HOLD. `wr_err` is `wr_done && err_q`.
- `req_valid` in SETUP or OPEN is not accepted. The requester must hold `req_addr`/`req_data` stable until `req_ready`.
- Reset mid-sequence:
  - All outputs return to their reset values immediately, including a `lat_en` forced to zero asynchronously.
  - The in-flight write is abandoned. The latch may hold partial data; this is acceptable.

## Timing
- Reset values:
  - state = IDLE
  - `lat_en` = 0
  - `lat_d` = 0
  - `addr_q` = 0
  - `err_q` = 0
  - `wr_done` = 0
  - `wr_err` = 0
  - `req_ready` = 1
- Accept at edge k:
  - SETUP during cycle k..k+1, with `lat_d` already valid.
  - OPEN during k+1..k+2, with `lat_en` asserted.
  - HOLD during k+2..k+3, with `lat_en` = 0, `lat_d` unchanged, and `wr_done` = 1.
- Guarantees:
  - `lat_d` is stable at least 1 cycle before `lat_en` rises and at least 1 cycle after it falls.
  - Exactly one `lat_en` bit is high, for exactly one cycle, per valid write.
- Throughput:
  - Back-to-back requests (accept in HOLD) give one write per 3 cycles.
  - Isolated requests from IDLE take 3 cycles plus return to IDLE.
- Latency from accept edge to `lat_en` rising is 1 cycle. Latency from accept edge to `wr_done` is 2 cycles.
- `lat_en` and `lat_d` are never both changing on the same edge.

## Test plan
- Reset with `rst_n`=0 for 3 cycles, then release:
  - `req_ready`=1, `lat_en`=4'b0000, `lat_d`=8'h00, `wr_done`=0 throughout.
- Single write with addr=2, data=8'hA5 accepted at edge k:
  - `lat_d`=8'hA5 from k.
  - `lat_en`=4'b0100 only in k+1..k+2.
  - `wr_done`=1 in k+2..k+3, `wr_err`=0.
  - `req_ready`=1 again after k+2.
- Back-to-back writes with `req_valid` held high, (0,8'h11) then (3,8'h33):
  - `lat_en` shows 4'b0001 and then, 3 cycles later, 4'b1000.
  - `lat_d` changes to 8'h33 only at the HOLD→SETUP edge, never while `lat_en` is nonzero.
- Out-of-range write with `DEPTH`=3, addr=3:
  - `lat_en` stays 0 throughout.
  - `wr_done`=1 and `wr_err`=1 for one cycle.
  - The next valid write (addr=1) produces `lat_en`=3'b010.
- Stalled request with `req_valid` asserted during SETUP/OPEN and `req_data` changed to 8'hFF:
  - Not accepted, `lat_d` unchanged.
  - Accepted in HOLD, so the following sequence writes 8'hFF.
- Reset mid-sequence with `rst_n` asserted during OPEN:
  - `lat_en` goes 0 asynchronously before the next edge, `lat_d`=0.
  - After release, state is IDLE and `wr_done` never pulses for the aborted write.
